// File: rtl/instr_fetch.sv
// instr_fetch: fetches 24-bit words, issues them by valid/ready and resolves class-11 branches
module instr_fetch (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [23:0] mem_data,
  output logic [23:0] code,
  output logic        code_valid,
  input  logic        code_ready,
  input  logic        branch_valid,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic [7:0]  pc,
  output logic        halted
);
  typedef enum logic [1:0] {FETCH, ISSUE, RESOLVE, HALT} state_t;
  state_t state, state_nxt;
  logic [7:0] pc_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= 8'h00;
      code  <= 24'h000000;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == FETCH && mem_ack) code <= mem_data;
    end
  end
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      FETCH: state_nxt = mem_ack ? ISSUE : FETCH;
      ISSUE: begin
        if (code_ready) begin
          state_nxt = (&code) ? HALT : (code[23:22] == 2'b11) ? RESOLVE : FETCH;
          pc_nxt    = (!(&code) && code[23:22] != 2'b11) ? pc + 8'd1 : pc;
        end
      end
      RESOLVE: begin
        if (branch_valid) begin
          state_nxt = FETCH;
          pc_nxt    = branch_taken ? branch_target : pc + 8'd1;
        end
      end
      default: state_nxt = HALT;
    endcase
  end
  always_comb begin
    mem_req    = state == FETCH;
    code_valid = state == ISSUE;
    halted     = state == HALT;
    mem_addr   = pc;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Producer side of the 24-bit instruction word consumed by the control unit: fetches words from instruction memory, issues them with a valid/ready handshake, and resolves class-11 (compare/branch) words before fetching further.

Interface
REQ-001 Clocking: one clock; reset is synchronous and active-high.
REQ-002 Ports, in order name / direction / width / meaning:
- clk / in / 1 / rising-edge clock.
- rst / in / 1 / synchronous active-high reset.
- mem_req / out / 1 / instruction memory read request.
- mem_addr / out / 8 / read address; always equals pc.
- mem_ack / in / 1 / memory has returned mem_data this cycle.
- mem_data / in / 24 / fetched instruction word.
- code / out / 24 / issued instruction word to the control unit.
- code_valid / out / 1 / code is valid.
- code_ready / in / 1 / consumer accepts code.
- branch_valid / in / 1 / branch resolution present this cycle.
- branch_taken / in / 1 / redirect to branch_target.
- branch_target / in / 8 / redirect address.
- pc / out / 8 / current program counter.
- halted / out / 1 / fetch stopped.

Function
REQ-003 The block SHALL have four states: FETCH, ISSUE, RESOLVE, HALT; all outputs SHALL be registered or decoded from state only.
REQ-004 FETCH: mem_req=1, code_valid=0; on mem_ack=1, code<=mem_data and next state ISSUE; without mem_ack, remain in FETCH with mem_addr stable.
REQ-005 ISSUE: mem_req=0, code_valid=1, code held stable until accepted; no acceptance while code_ready=0.
REQ-006 Acceptance in ISSUE (code_ready=1) SHALL be decoded in this priority order:
- code==24'hFFFFFF: HALT, pc unchanged.
- code[23:22]==2'b11: RESOLVE, pc unchanged.
- otherwise: pc<=pc+1, FETCH.
REQ-007 RESOLVE: code_valid=0, mem_req=0; branch_valid is sampled only in this state and ignored elsewhere.
- branch_valid=1 and branch_taken=1: pc<=branch_target, FETCH.
- branch_valid=1 and branch_taken=0: pc<=pc+1, FETCH.
- branch_valid=0: remain in RESOLVE.
REQ-008 pc arithmetic SHALL be 8-bit modulo: pc+1 from 8'hFF SHALL wrap to 8'h00 with no flag.
REQ-009 HALT: halted=1, mem_req=0, code_valid=0; the block remains in HALT until rst.
REQ-010 mem_ack outside FETCH SHALL be ignored; mem_data SHALL NOT be latched.
REQ-011 Minimum latency SHALL be one FETCH cycle (mem_ack=1 the same cycle), then code_valid=1 in the following cycle; back-to-back throughput SHALL be one word per 2 cycles.
REQ-012 branch_target==pc SHALL be legal and refetch the same address.

Reset
REQ-013 With rst=1 at a rising edge, the following SHALL hold at the next cycle regardless of state:
- state=FETCH, pc=8'h00, code=24'h000000.
- code_valid=0, halted=0, mem_req=1, mem_addr=8'h00.
REQ-014 Reset in any state SHALL abort the operation in progress: a pending mem_ack or branch resolution in the reset cycle SHALL be discarded.
REQ-015 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-016 Reset, then mem_ack=1 with mem_data=24'h000130, code_ready=1 -> code_valid=1 next cycle, code=24'h000130; after acceptance pc=8'h01 and mem_req=1.
REQ-017 code_ready=0 for 5 cycles in ISSUE -> code_valid held at 1, code unchanged, pc unchanged; accepted on cycle 6.
REQ-018 Issue 24'hC01000 (class 11), then hold branch_valid=0 for 3 cycles -> stays in RESOLVE with mem_req=0; then branch_valid=1, branch_taken=1, branch_target=8'h40 -> FETCH with mem_addr=8'h40.
REQ-019 Fetches from pc=8'hFF of a class-01 word -> after acceptance pc=8'h00.
REQ-020 Accept 24'hFFFFFF -> halted=1 permanently, mem_req=0 despite mem_ack=1; then rst=1 -> pc=8'h00, halted=0, mem_req=1.
REQ-021 Assert rst=1 in RESOLVE together with branch_valid=1, branch_taken=1, branch_target=8'h20 -> pc=8'h00, not 8'h20.
